// File: rtl/mat_stream_tx.sv
// Serialises one flat M x N matrix into a row-major element stream with
// row/col tags and a last flag; a two-state FSM gates loading versus sending.
module mat_stream_tx #(
  parameter int DATA_LEN = 32,
  parameter int M        = 8,
  parameter int N        = 8,
  parameter int ROW_SIZE = DATA_LEN*N,
  parameter int MAT_SIZE = DATA_LEN*N*M,
  parameter int RW       = (M > 1) ? $clog2(M) : 1,
  parameter int CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_mat_valid,
  output logic                o_mat_ready,
  input  logic [MAT_SIZE-1:0] i_mat_data,
  output logic                o_elem_valid,
  input  logic                i_elem_ready,
  output logic [DATA_LEN-1:0] o_elem_data,
  output logic [RW-1:0]       o_elem_row,
  output logic [CW-1:0]       o_elem_col,
  output logic                o_elem_last,
  output logic                o_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [MAT_SIZE-1:0] mat_q, mat_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                row_end, col_end, last_w;

  // Wrap on explicit compares so non-power-of-2 shapes step correctly.
  assign row_end = (row_q == RW'(M-1));
  assign col_end = (col_q == CW'(N-1));
  assign last_w  = (state_q == SEND) && row_end && col_end;

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (i_mat_valid) begin
          mat_d   = i_mat_data;
          row_d   = '0;
          col_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_elem_ready) begin
          if (last_w) begin
            row_d   = '0;
            col_d   = '0;
            state_d = IDLE;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      mat_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Outputs come only from registered state, so neither handshake side
  // sees a combinational path from the other.
  assign o_mat_ready  = (state_q == IDLE);
  assign o_elem_valid = (state_q == SEND);
  assign o_busy       = (state_q == SEND);
  assign o_elem_row   = row_q;
  assign o_elem_col   = col_q;
  assign o_elem_last  = last_w;
  assign o_elem_data  = (state_q == SEND)
                      ? mat_q[ROW_SIZE*int'(row_q) + DATA_LEN*int'(col_q) +: DATA_LEN]
                      : '0;

endmodule

// File: tb/tb_mat_stream_tx.sv
// Directed bench for mat_stream_tx: 8x8 default instance plus a 1x3 instance.
module tb_mat_stream_tx;
  localparam int DL = 32;
  localparam int MS = DL*64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mat_valid, mat_ready, elem_valid, elem_ready, elem_last, busy;
  logic [MS-1:0] mat_data;
  logic [DL-1:0] elem_data;
  logic [2:0]    elem_row, elem_col;

  logic          d_mat_valid, d_mat_ready, d_elem_valid, d_elem_ready, d_elem_last, d_busy;
  logic [95:0]   d_mat_data;
  logic [DL-1:0] d_elem_data;
  logic [0:0]    d_elem_row;
  logic [1:0]    d_elem_col;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_stream_tx dut (
    .i_clk(clk), .i_rst(rst), .i_mat_valid(mat_valid), .o_mat_ready(mat_ready),
    .i_mat_data(mat_data), .o_elem_valid(elem_valid), .i_elem_ready(elem_ready),
    .o_elem_data(elem_data), .o_elem_row(elem_row), .o_elem_col(elem_col),
    .o_elem_last(elem_last), .o_busy(busy)
  );

  mat_stream_tx #(.DATA_LEN(32), .M(1), .N(3)) dut_d (
    .i_clk(clk), .i_rst(rst), .i_mat_valid(d_mat_valid), .o_mat_ready(d_mat_ready),
    .i_mat_data(d_mat_data), .o_elem_valid(d_elem_valid), .i_elem_ready(d_elem_ready),
    .o_elem_data(d_elem_data), .o_elem_row(d_elem_row), .o_elem_col(d_elem_col),
    .o_elem_last(d_elem_last), .o_busy(d_busy)
  );

  // kind 0: r*16+c, kind 1: signed corners, kind 2: 1000+r*16+c
  function automatic logic [DL-1:0] pat(input int kind, input int r, input int c);
    if (kind == 1) begin
      if (r == 0 && c == 0) return 32'hFFFF_FFF6;
      if (r == 7 && c == 7) return 32'h8000_0000;
      return '0;
    end
    if (kind == 2) return DL'(1000 + r*16 + c);
    return DL'(r*16 + c);
  endfunction

  function automatic logic [MS-1:0] build(input int kind);
    logic [MS-1:0] m;
    m = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[256*r + 32*c +: 32] = pat(kind, r, c);
    return m;
  endfunction

  // Loads a matrix: returns at the negedge after the capturing edge.
  task automatic load(input int kind);
    mat_data  = build(kind);
    mat_valid = 1'b1;
    @(negedge clk);
    mat_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    elem_ready = 1'b1;
    while (elem_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (elem_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout valid=%b required 0", elem_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({mat_ready, elem_valid, busy, elem_last} !== 4'b1000 || elem_row !== 3'd0 ||
        elem_col !== 3'd0 || elem_data !== 32'd0) begin
      errors++;
      $display("FAIL reset rdy/vld/busy/last=%b row=%0d col=%0d data=%h required 1000 0 0 0",
               {mat_ready, elem_valid, busy, elem_last}, elem_row, elem_col, elem_data);
    end
    checks++;
    if ({d_mat_ready, d_elem_valid, d_busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_small rdy/vld/busy=%b required 100", {d_mat_ready, d_elem_valid, d_busy});
    end
  endtask

  task automatic test_basic_stream(input int kind, input string tag);
    elem_ready = 1'b1;
    load(kind);
    for (int i = 0; i < 64; i++) begin
      int r, c;
      r = i / 8;
      c = i % 8;
      checks++;
      if (elem_valid !== 1'b1 || busy !== 1'b1 || mat_ready !== 1'b0 ||
          elem_data !== pat(kind, r, c) || elem_row !== 3'(r) || elem_col !== 3'(c) ||
          elem_last !== (i == 63)) begin
        errors++;
        $display("FAIL %s_elem%0d vld=%b data=%h row=%0d col=%0d last=%b required 1 %h %0d %0d %b",
                 tag, i, elem_valid, elem_data, elem_row, elem_col, elem_last,
                 pat(kind, r, c), r, c, (i == 63));
      end
      @(negedge clk);
    end
    checks++;
    if (mat_ready !== 1'b1 || elem_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_return rdy=%b vld=%b busy=%b required 1 0 0", tag, mat_ready, elem_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int e, stalls, cyc;
    e = 0; stalls = 0; cyc = 0;
    elem_ready = 1'b1;
    load(0);
    while (e < 64 && cyc < 200) begin
      checks++;
      if (elem_valid !== 1'b1 || elem_data !== pat(0, e/8, e%8) ||
          elem_row !== 3'(e/8) || elem_col !== 3'(e%8)) begin
        errors++;
        $display("FAIL bp_elem%0d vld=%b data=%0d row=%0d col=%0d required 1 %0d %0d %0d",
                 e, elem_valid, elem_data, elem_row, elem_col, pat(0, e/8, e%8), e/8, e%8);
      end
      if (e == 21 && stalls < 3) begin
        elem_ready = 1'b0;
        stalls++;
      end else begin
        elem_ready = 1'b1;
        e++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (e != 64 || cyc != 67 || elem_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_total transfers=%0d cycles=%0d vld=%b required 64 67 0", e, cyc, elem_valid);
    end
  endtask

  task automatic test_isolation();
    elem_ready = 1'b1;
    load(0);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        mat_data  = build(2);
        mat_valid = 1'b1;
      end
      checks++;
      if (mat_ready !== 1'b0 || elem_data !== pat(0, i/8, i%8)) begin
        errors++;
        $display("FAIL iso_elem%0d rdy=%b data=%0d required 0 %0d", i, mat_ready, elem_data, pat(0, i/8, i%8));
      end
      @(negedge clk);
    end
    checks++;
    if (mat_ready !== 1'b1 || elem_valid !== 1'b0) begin
      errors++;
      $display("FAIL iso_idle rdy=%b vld=%b required 1 0", mat_ready, elem_valid);
    end
    @(negedge clk);
    mat_valid = 1'b0;
    checks++;
    if (elem_valid !== 1'b1 || elem_data !== pat(2, 0, 0)) begin
      errors++;
      $display("FAIL iso_second vld=%b data=%0d required 1 %0d", elem_valid, elem_data, pat(2, 0, 0));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    elem_ready = 1'b1;
    load(0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (elem_valid !== 1'b0 || mat_ready !== 1'b1 || busy !== 1'b0 ||
        elem_row !== 3'd0 || elem_col !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid vld=%b rdy=%b busy=%b row=%0d col=%0d required 0 1 0 0 0",
               elem_valid, mat_ready, busy, elem_row, elem_col);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (elem_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_emit vld=%b required 0", elem_valid);
    end
    load(0);
    checks++;
    if (elem_valid !== 1'b1 || elem_data !== 32'd0 || elem_row !== 3'd0 || elem_col !== 3'd0) begin
      errors++;
      $display("FAIL rst_restart vld=%b data=%0d row=%0d col=%0d required 1 0 0 0",
               elem_valid, elem_data, elem_row, elem_col);
    end
    @(negedge clk);
    checks++;
    if (elem_data !== 32'd1 || elem_col !== 3'd1) begin
      errors++;
      $display("FAIL rst_second data=%0d col=%0d required 1 1", elem_data, elem_col);
    end
    drain();
  endtask

  task automatic test_degenerate();
    d_elem_ready = 1'b1;
    d_mat_data   = {32'd7, 32'd6, 32'd5};
    d_mat_valid  = 1'b1;
    @(negedge clk);
    d_mat_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (d_elem_valid !== 1'b1 || d_elem_data !== DL'(5 + i) || d_elem_row !== 1'b0 ||
          d_elem_col !== 2'(i) || d_elem_last !== (i == 2)) begin
        errors++;
        $display("FAIL deg_elem%0d vld=%b data=%0d row=%0d col=%0d last=%b required 1 %0d 0 %0d %b",
                 i, d_elem_valid, d_elem_data, d_elem_row, d_elem_col, d_elem_last, 5 + i, i, (i == 2));
      end
      @(negedge clk);
    end
    checks++;
    if (d_elem_valid !== 1'b0 || d_mat_ready !== 1'b1) begin
      errors++;
      $display("FAIL deg_return vld=%b rdy=%b required 0 1", d_elem_valid, d_mat_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    mat_valid = 1'b0; mat_data = '0; elem_ready = 1'b0;
    d_mat_valid = 1'b0; d_mat_data = '0; d_elem_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic_stream(0, "basic");
    test_backpressure();
    test_basic_stream(1, "signed");
    test_isolation();
    test_reset_mid();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
